flash_phy_rd_buf_alloc: RTL and testbench
=========================================

# flash_phy_rd_buf_alloc

Read-buffer allocator for one flash bank's PHY read path. It sits directly upstream of the read-buffer dependency tracker. For each incoming read it detects a buffer hit or chooses a buffer to allocate, using the tracker's per-buffer dependency vector to avoid evicting buffers still owed to queued responses. It also tracks each buffer's lifecycle (invalid / in-flight / valid / stale) as flash reads complete or the cache is invalidated by program/erase.

## Interface
- NumBuf, 4, number of read buffers (power of two, ≥2)
- AddrW, 16, bank word-address width used as buffer tag
- clk_i  input  1  clock
- rst_ni  input  1  reset, synchronous, active-low
- req_i  input  1  read lookup request valid
- addr_i  input  AddrW  requested word address
- part_i  input  1  partition (0 data, 1 info); part of the tag
- dependency_i  input  NumBuf  per-buffer "owed to rsp FIFO" flags from the dependency tracker
- rd_done_i  input  1  flash read for a buffer completed this cycle
- rd_done_buf_i  input  NumBuf  one-hot buffer completing
- rd_err_i  input  1  completing read had an error
- inv_i  input  1  invalidate all buffers (program/erase started)
- hit_o  output  NumBuf  one-hot hit buffer, 0 if miss
- alloc_o  output  NumBuf  one-hot buffer to allocate on miss, 0 otherwise
- stall_o  output  1  request cannot be accepted this cycle
- buf_state_o  output  NumBuf*2  per-buffer state, debug/assertions

## Operation
- Per-buffer state (from the package): Invalid, Wip, Valid, WipStale. Each buffer holds a tag {part, addr}.
- Hit: state ∈ {Valid, Wip} and tag == {part_i, addr_i}. At most one hit (asserted). Invalid and WipStale never hit.
- Miss: a buffer is candidate if its state ∈ {Invalid, Valid} and dependency_i bit is 0.
  - Selection: the first Invalid candidate at or after rr_ptr, circularly; otherwise the first Valid candidate at or after rr_ptr.
- stall_o = req_i & (inv_i | (no hit & no candidate)).
- hit_o and alloc_o are qualified by req_i & !stall_o. They are mutually exclusive.
- Accept: req_i & !stall_o.
  - On a miss, the chosen buffer becomes Wip, its tag is loaded, and rr_ptr becomes chosen index + 1 (mod NumBuf).
  - On a hit, no state change.
- rd_done_i on buffer b:
  - Wip → Valid, or Wip → Invalid if rd_err_i.
  - WipStale → Invalid.
  - Done on Invalid or Valid is illegal (asserted) and ignored.
- inv_i: Valid → Invalid, Wip → WipStale, other states unchanged.
- Simultaneous events:
  - rd_done_i and inv_i on the same Wip buffer: done wins (Valid or Invalid), then inv applies, giving Invalid.
  - Accept and rd_done_i never target the same buffer, because Wip is not a candidate.
  - Accept and inv_i cannot coincide, because inv stalls.
- dependency_i only gates candidacy; it never changes state.

## Timing
- hit_o, alloc_o and stall_o are combinational from inputs and registered state, with zero latency.
- State, tag and rr_ptr update on the clock edge after accept/done/inv. The allocated buffer reads Wip and can hit from the next cycle.
- Reset (synchronous, rst_ni low at the edge):
  - all buffers Invalid, tags 0, rr_ptr 0;
  - hit_o = 0, alloc_o = 0, stall_o = 0 while req_i = 0;
  - buf_state_o = all Invalid.
- Reset mid-read drops all in-flight state. A later rd_done_i targets an Invalid buffer and is ignored.
- rr_ptr wraps from NumBuf-1 to 0.

## Structure
- flash_phy_pkg gains:
  - rd_buf_state_e (2-bit: Invalid = 0, Wip = 1, Valid = 2, WipStale = 3);
  - rd_buf_tag_t {part, addr}.
- It reuses the existing NumBuf constant as the parameter default.
- One sub-module, flash_phy_rd_buf_pick: a combinational circular first-set finder (request vector, start pointer → one-hot grant).
  - It is instanced twice, once for the Invalid candidates and once for the Valid candidates.

## Test plan
- Reset, then req addr 0x10 part 0: alloc_o = 0001, stall_o = 0. After rd_done_buf_i = 0001, a req at 0x10 gives hit_o = 0001 and alloc_o = 0.
- Misses to 0x1, 0x2, 0x3, 0x4 with no done: alloc_o = 0001, 0010, 0100, 1000 in turn, rr_ptr wraps to 0. A 5th miss gives stall_o = 1, because all buffers are Wip.
- All four Valid, dependency_i = 1011, miss: alloc_o = 0100. With dependency_i = 1111: stall_o = 1, hit_o = 0.
- Buffer 0 Wip, inv_i pulse: state becomes WipStale. A req at the same address misses. rd_done then gives Invalid, and the next miss allocates buffer 0.
- rd_done_i with rd_err_i on buffer 1: Invalid, and a req at its address misses.
- Buffers 0 and 2 Invalid, 1 and 3 Valid, rr_ptr = 1, miss: alloc_o = 0100, because an Invalid buffer is preferred over a Valid one.

Source files
------------

// File: rtl/flash_phy_pkg.sv
// flash_phy_pkg: shared types and constants for the flash PHY.
//   NumBuf        number of read buffers per bank
//   BankAddrW     bank word-address width
//   rd_buf_state_e  read-buffer lifecycle state
//   rd_buf_tag_t    read-buffer tag {part, addr}
package flash_phy_pkg;

  localparam int unsigned NumBuf    = 4;
  localparam int unsigned BankAddrW = 16;

  typedef enum logic [1:0] {
    RdBufInvalid  = 2'd0,
    RdBufWip      = 2'd1,
    RdBufValid    = 2'd2,
    RdBufWipStale = 2'd3
  } rd_buf_state_e;

  typedef struct packed {
    logic                 part;
    logic [BankAddrW-1:0] addr;
  } rd_buf_tag_t;

endpackage

// File: rtl/flash_phy_rd_buf_pick.sv
// flash_phy_rd_buf_pick: combinational circular first-set finder.
//   req_i    request vector
//   ptr_i    index to start the search from (wraps past N-1 to 0)
//   gnt_o    one-hot grant of the first set request at or after ptr_i
//   idx_o    binary index of the granted bit (0 when nothing granted)
//   found_o  at least one request was set
module flash_phy_rd_buf_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned PtrW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [PtrW-1:0] idx_o,
  output logic            found_o
);

  always_comb begin
    logic [PtrW-1:0] idx;
    gnt_o   = '0;
    idx_o   = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // N is a power of two, so the PtrW-bit sum wraps naturally.
      idx = ptr_i + PtrW'(k);
      if (!found_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        idx_o      = idx;
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flash_phy_rd_buf_alloc.sv
// flash_phy_rd_buf_alloc: read-buffer hit detection and allocation for one bank.
//   clk_i, rst_ni       clock, synchronous active-low reset
//   req_i, addr_i,
//   part_i              read lookup request and its tag
//   dependency_i        buffers still owed to the response FIFO (not evictable)
//   rd_done_i,
//   rd_done_buf_i,
//   rd_err_i            flash read completion for a one-hot buffer
//   inv_i               invalidate all buffers (program/erase started)
//   hit_o, alloc_o      one-hot hit / allocation, qualified by acceptance
//   stall_o             request cannot be accepted this cycle
//   buf_state_o         packed per-buffer state, buffer 0 in the low bits
module flash_phy_rd_buf_alloc #(
  parameter int unsigned NumBuf = flash_phy_pkg::NumBuf,
  parameter int unsigned AddrW  = flash_phy_pkg::BankAddrW
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic [AddrW-1:0]    addr_i,
  input  logic                part_i,
  input  logic [NumBuf-1:0]   dependency_i,
  input  logic                rd_done_i,
  input  logic [NumBuf-1:0]   rd_done_buf_i,
  input  logic                rd_err_i,
  input  logic                inv_i,
  output logic [NumBuf-1:0]   hit_o,
  output logic [NumBuf-1:0]   alloc_o,
  output logic                stall_o,
  output logic [2*NumBuf-1:0] buf_state_o
);

  import flash_phy_pkg::*;

  localparam int unsigned PtrW = $clog2(NumBuf);

  typedef struct packed {
    logic             part;
    logic [AddrW-1:0] addr;
  } tag_t;

  rd_buf_state_e   state_q [NumBuf];
  rd_buf_state_e   state_d [NumBuf];
  tag_t            tag_q   [NumBuf];
  tag_t            tag_d   [NumBuf];
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;

  tag_t              req_tag;
  logic [NumBuf-1:0] hit_raw, inv_cand, val_cand, inv_gnt, val_gnt, busy;
  logic [PtrW-1:0]   inv_idx, val_idx, alloc_idx;
  logic              inv_found, val_found, any_hit, accept, miss_accept;

  assign req_tag = {part_i, addr_i};

  always_comb begin
    hit_raw  = '0;
    inv_cand = '0;
    val_cand = '0;
    busy     = '0;
    for (int unsigned b = 0; b < NumBuf; b++) begin
      hit_raw[b]  = (state_q[b] == RdBufValid || state_q[b] == RdBufWip) &&
                    (tag_q[b] == req_tag);
      inv_cand[b] = (state_q[b] == RdBufInvalid) && !dependency_i[b];
      val_cand[b] = (state_q[b] == RdBufValid) && !dependency_i[b];
      busy[b]     = (state_q[b] == RdBufWip) || (state_q[b] == RdBufWipStale);
    end
  end

  // Empty buffers are always preferred over evicting a valid one.
  flash_phy_rd_buf_pick #(
    .N (NumBuf)
  ) u_pick_invalid (
    .req_i   (inv_cand),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (inv_gnt),
    .idx_o   (inv_idx),
    .found_o (inv_found)
  );

  flash_phy_rd_buf_pick #(
    .N (NumBuf)
  ) u_pick_valid (
    .req_i   (val_cand),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (val_gnt),
    .idx_o   (val_idx),
    .found_o (val_found)
  );

  assign any_hit     = |hit_raw;
  assign stall_o     = req_i & (inv_i | (~any_hit & ~inv_found & ~val_found));
  assign accept      = req_i & ~stall_o;
  assign miss_accept = accept & ~any_hit;
  assign alloc_idx   = inv_found ? inv_idx : val_idx;
  assign hit_o       = accept ? hit_raw : '0;
  assign alloc_o     = miss_accept ? (inv_found ? inv_gnt : val_gnt) : '0;

  // Completion first, then invalidation, then allocation. Allocation never
  // collides with the other two: it stalls under inv_i and only picks
  // Invalid/Valid buffers, which never complete.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int unsigned b = 0; b < NumBuf; b++) begin
      state_d[b] = state_q[b];
      tag_d[b]   = tag_q[b];
      if (rd_done_i && rd_done_buf_i[b]) begin
        unique case (state_q[b])
          RdBufWip:      state_d[b] = rd_err_i ? RdBufInvalid : RdBufValid;
          RdBufWipStale: state_d[b] = RdBufInvalid;
          default:       ;
        endcase
      end
      if (inv_i) begin
        unique case (state_d[b])
          RdBufValid: state_d[b] = RdBufInvalid;
          RdBufWip:   state_d[b] = RdBufWipStale;
          default:    ;
        endcase
      end
      if (alloc_o[b]) begin
        state_d[b] = RdBufWip;
        tag_d[b]   = req_tag;
      end
    end
    if (miss_accept) begin
      rr_ptr_d = alloc_idx + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned b = 0; b < NumBuf; b++) begin
        state_q[b] <= RdBufInvalid;
        tag_q[b]   <= '0;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int unsigned b = 0; b < NumBuf; b++) begin
        state_q[b] <= state_d[b];
        tag_q[b]   <= tag_d[b];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    buf_state_o = '0;
    for (int unsigned b = 0; b < NumBuf; b++) begin
      buf_state_o[2*b +: 2] = state_q[b];
    end
  end

  // Allocation only happens on a miss, so a tag is never live in two buffers.
  hit_onehot_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(hit_raw));

  // Completions only target a buffer with a read outstanding.
  done_legal_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rd_done_i |-> ($onehot(rd_done_buf_i) && ((rd_done_buf_i & busy) != '0)));

endmodule

// File: tb/tb_flash_phy_rd_buf_alloc.sv
module tb_flash_phy_rd_buf_alloc;

  localparam int unsigned NB = 4;
  localparam int unsigned AW = 16;
  localparam int SI = 0, SW = 1, SV = 2, SS = 3;

  logic          clk = 1'b0;
  logic          rst_ni, req_i, part_i, rd_done_i, rd_err_i, inv_i, stall_o;
  logic [AW-1:0] addr_i;
  logic [NB-1:0] dependency_i, rd_done_buf_i, hit_o, alloc_o;
  logic [2*NB-1:0] buf_state_o;

  always #5 clk = ~clk;

  flash_phy_rd_buf_alloc #(
    .NumBuf (NB),
    .AddrW  (AW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .addr_i        (addr_i),
    .part_i        (part_i),
    .dependency_i  (dependency_i),
    .rd_done_i     (rd_done_i),
    .rd_done_buf_i (rd_done_buf_i),
    .rd_err_i      (rd_err_i),
    .inv_i         (inv_i),
    .hit_o         (hit_o),
    .alloc_o       (alloc_o),
    .stall_o       (stall_o),
    .buf_state_o   (buf_state_o)
  );

  typedef struct packed {
    logic          rst;
    logic          req;
    logic [AW-1:0] addr;
    logic          part;
    logic [NB-1:0] dep;
    logic [NB-1:0] dbuf;
    logic          err;
    logic          inv;
    logic [NB-1:0] hit;
    logic [NB-1:0] alloc;
    logic          stall;
    logic [7:0]    st;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: per-buffer state, tag and round-robin pointer.
  int            m_st  [NB];
  logic [AW:0]   m_tag [NB];
  int            m_ptr;
  int            wl[$];
  int            p;
  logic [NB-1:0] eh, ea;
  logic          es;

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h want %0h", name, idx, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic req, input logic [AW-1:0] addr, input logic part,
                              input logic [NB-1:0] dep, input logic [NB-1:0] dbuf,
                              input logic err, input logic inv, input logic [NB-1:0] hit,
                              input logic [NB-1:0] alloc, input logic stall,
                              input logic [7:0] st);
    vec_t v;
    v = '{rst: 1'b0, req: req, addr: addr, part: part, dep: dep, dbuf: dbuf, err: err,
          inv: inv, hit: hit, alloc: alloc, stall: stall, st: st};
    return v;
  endfunction

  function automatic vec_t rs();
    vec_t v;
    v = '0;
    v.rst = 1'b1;
    return v;
  endfunction

  task automatic apply(input vec_t r, input int idx);
    rst_ni        = !r.rst;
    req_i         = r.req;
    addr_i        = r.addr;
    part_i        = r.part;
    dependency_i  = r.dep;
    rd_done_buf_i = r.dbuf;
    rd_done_i     = |r.dbuf;
    rd_err_i      = r.err;
    inv_i         = r.inv;
    #4;
    if (!r.rst) begin
      chk("hit", idx, 32'(hit_o), 32'(r.hit));
      chk("alloc", idx, 32'(alloc_o), 32'(r.alloc));
      chk("stall", idx, 32'(stall_o), 32'(r.stall));
      chk("state", idx, 32'(buf_state_o), 32'(r.st));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int b = 0; b < int'(NB); b++) begin
      m_st[b]  = SI;
      m_tag[b] = '0;
    end
    m_ptr = 0;
  endtask

  function automatic logic [7:0] model_state();
    logic [7:0] s;
    s = '0;
    for (int b = 0; b < int'(NB); b++) s[2*b +: 2] = 2'(m_st[b]);
    return s;
  endfunction

  task automatic model_eval(output logic [NB-1:0] h_e, output logic [NB-1:0] a_e,
                            output logic s_e);
    logic [NB-1:0] h;
    int            pick;
    int            b;
    h    = '0;
    pick = -1;
    for (int i = 0; i < int'(NB); i++)
      if ((m_st[i] == SW || m_st[i] == SV) && m_tag[i] == {part_i, addr_i}) h[i] = 1'b1;
    for (int k = 0; k < int'(NB); k++) begin
      b = (m_ptr + k) % int'(NB);
      if (pick < 0 && m_st[b] == SI && !dependency_i[b]) pick = b;
    end
    for (int k = 0; k < int'(NB); k++) begin
      b = (m_ptr + k) % int'(NB);
      if (pick < 0 && m_st[b] == SV && !dependency_i[b]) pick = b;
    end
    s_e = req_i && (inv_i || (h == '0 && pick < 0));
    h_e = (req_i && !s_e) ? h : '0;
    a_e = '0;
    if (req_i && !s_e && h == '0) a_e[pick] = 1'b1;
  endtask

  task automatic model_update(input logic [NB-1:0] a_e);
    if (!rst_ni) begin
      model_reset();
      return;
    end
    for (int b = 0; b < int'(NB); b++) begin
      if (rd_done_i && rd_done_buf_i[b]) begin
        if (m_st[b] == SW) m_st[b] = rd_err_i ? SI : SV;
        else if (m_st[b] == SS) m_st[b] = SI;
      end
    end
    if (inv_i) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (m_st[b] == SV) m_st[b] = SI;
        else if (m_st[b] == SW) m_st[b] = SS;
      end
    end
    for (int b = 0; b < int'(NB); b++) begin
      if (a_e[b]) begin
        m_st[b]  = SW;
        m_tag[b] = {part_i, addr_i};
        m_ptr    = (b + 1) % int'(NB);
      end
    end
  endtask

  initial begin
    // Directed vectors: req addr part dep dbuf err inv | hit alloc stall state.
    tbl.push_back(rs());
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(1, 16'h10, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h1, 0, 8'h00));
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h1, 0, 0, 4'h0, 4'h0, 0, 8'h01));
    tbl.push_back(mk(1, 16'h10, 0, 4'h0, 4'h0, 0, 0, 4'h1, 4'h0, 0, 8'h02));
    // Fill all four, wrap the pointer, then stall with everything in flight.
    tbl.push_back(rs());
    tbl.push_back(mk(1, 16'h01, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h1, 0, 8'h00));
    tbl.push_back(mk(1, 16'h02, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h2, 0, 8'h01));
    tbl.push_back(mk(1, 16'h03, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h4, 0, 8'h05));
    tbl.push_back(mk(1, 16'h04, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h8, 0, 8'h15));
    tbl.push_back(mk(1, 16'h05, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 1, 8'h55));
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h1, 0, 0, 4'h0, 4'h0, 0, 8'h55));
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h2, 0, 0, 4'h0, 4'h0, 0, 8'h56));
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h4, 0, 0, 4'h0, 4'h0, 0, 8'h5A));
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h8, 0, 0, 4'h0, 4'h0, 0, 8'h6A));
    // Dependency gating of eviction, but not of hits.
    tbl.push_back(mk(1, 16'h06, 0, 4'hB, 4'h0, 0, 0, 4'h0, 4'h4, 0, 8'hAA));
    tbl.push_back(mk(1, 16'h07, 0, 4'hF, 4'h0, 0, 0, 4'h0, 4'h0, 1, 8'h9A));
    tbl.push_back(mk(1, 16'h01, 0, 4'hF, 4'h0, 0, 0, 4'h1, 4'h0, 0, 8'h9A));
    // Invalidate with buffer 2 in flight; stale buffer must not hit.
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 8'h9A));
    tbl.push_back(mk(1, 16'h06, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h8, 0, 8'h30));
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h4, 0, 0, 4'h0, 4'h0, 0, 8'h70));
    tbl.push_back(mk(1, 16'h08, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h1, 0, 8'h40));
    // Request under invalidate stalls even though it would hit.
    tbl.push_back(mk(1, 16'h06, 0, 4'h0, 4'h0, 0, 1, 4'h0, 4'h0, 1, 8'h41));
    // Allocate alongside a completion of another buffer.
    tbl.push_back(mk(1, 16'h09, 0, 4'h0, 4'h1, 0, 0, 4'h0, 4'h2, 0, 8'hC3));
    // Done and invalidate on the same in-flight buffer ends Invalid.
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h2, 0, 1, 4'h0, 4'h0, 0, 8'hC4));
    tbl.push_back(mk(1, 16'h09, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h4, 0, 8'hC0));
    // Errored read leaves the buffer Invalid, so the address misses again.
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h4, 1, 0, 4'h0, 4'h0, 0, 8'hD0));
    tbl.push_back(mk(1, 16'h09, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h1, 0, 8'hC0));
    // Invalid preferred over Valid with rr_ptr = 1.
    tbl.push_back(rs());
    tbl.push_back(mk(1, 16'h0A, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h1, 0, 8'h00));
    tbl.push_back(mk(1, 16'h0B, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h2, 0, 8'h01));
    tbl.push_back(mk(1, 16'h0C, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h4, 0, 8'h05));
    tbl.push_back(mk(1, 16'h0D, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h8, 0, 8'h15));
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h1, 0, 0, 4'h0, 4'h0, 0, 8'h55));
    tbl.push_back(mk(1, 16'h0E, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h1, 0, 8'h56));
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h1, 1, 0, 4'h0, 4'h0, 0, 8'h55));
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h2, 0, 0, 4'h0, 4'h0, 0, 8'h54));
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h4, 1, 0, 4'h0, 4'h0, 0, 8'h58));
    tbl.push_back(mk(0, 16'h00, 0, 4'h0, 4'h8, 0, 0, 4'h0, 4'h0, 0, 8'h48));
    tbl.push_back(mk(1, 16'h0F, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h4, 0, 8'h88));
    // Partition bit is part of the tag.
    tbl.push_back(mk(1, 16'h0B, 1, 4'h0, 4'h0, 0, 0, 4'h0, 4'h1, 0, 8'h98));
    tbl.push_back(mk(1, 16'h0B, 0, 4'h0, 4'h0, 0, 0, 4'h2, 4'h0, 0, 8'h99));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Randomized phase against the reference model.
    apply(rs(), -1);
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_ni       = ($urandom_range(0, 299) != 0);
      req_i        = ($urandom_range(0, 9) < 7);
      addr_i       = AW'($urandom_range(0, 7));
      part_i       = 1'($urandom_range(0, 1));
      dependency_i = NB'($urandom & $urandom);
      inv_i        = ($urandom_range(0, 19) == 0);
      rd_done_i     = 1'b0;
      rd_done_buf_i = '0;
      rd_err_i      = 1'b0;
      wl.delete();
      for (int b = 0; b < int'(NB); b++) if (m_st[b] == SW || m_st[b] == SS) wl.push_back(b);
      if (wl.size() > 0 && $urandom_range(0, 2) == 0) begin
        p                = wl[$urandom_range(0, wl.size() - 1)];
        rd_done_i        = 1'b1;
        rd_done_buf_i[p] = 1'b1;
        rd_err_i         = ($urandom_range(0, 3) == 0);
      end
      #4;
      model_eval(eh, ea, es);
      chk("r_hit", n, 32'(hit_o), 32'(eh));
      chk("r_alloc", n, 32'(alloc_o), 32'(ea));
      chk("r_stall", n, 32'(stall_o), 32'(es));
      chk("r_state", n, 32'(buf_state_o), 32'(model_state()));
      @(posedge clk);
      #1;
      model_update(ea);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
